// File: rtl/mac_accumulator.sv
// Unsigned multiply-accumulate back end: sums a counted run of products and reports the result.
// Define MAC_ACC_SAT_EN to clamp on overflow instead of wrapping.
module mac_accumulator #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 40,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_acc_start,
  input  logic [LEN_WIDTH-1:0] i_acc_len,
  input  logic [IN_WIDTH-1:0]  i_acc_val,
  input  logic                 i_acc_valid,
  output logic                 o_acc_busy,
  output logic [ACC_WIDTH-1:0] o_acc_val,
  output logic                 o_acc_valid,
  output logic                 o_acc_ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]           state;
  logic [ACC_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0] cnt;
  logic                 ovf;

  logic                 start_ok;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 carry;
  logic [ACC_WIDTH-1:0] acc_next;

  // A start while accumulating is dropped so a running dot product is never disturbed.
  assign start_ok = i_acc_start && (state != ACCUM);

  assign sum_ext = {1'b0, acc} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, i_acc_val};
  assign carry   = sum_ext[ACC_WIDTH];

  always_comb begin
    acc_next = sum_ext[ACC_WIDTH-1:0];
`ifdef MAC_ACC_SAT_EN
    if (carry) acc_next = '1;
`endif
  end

  // NOTE: reset is synchronous, so it sits inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (state != ACCUM) begin
      // IDLE and DONE share one path; DONE falls back to IDLE unless a new run starts.
      if (start_ok) begin
        acc <= '0;
        ovf <= 1'b0;
        cnt <= i_acc_len;
        state <= (i_acc_len == '0) ? DONE : ACCUM;
      end else begin
        state <= IDLE;
      end
    end else if (i_acc_valid) begin
      acc <= acc_next;
      ovf <= ovf | carry;
      cnt <= cnt - LEN_WIDTH'(1);
      if (cnt == LEN_WIDTH'(1)) state <= DONE;
    end
  end

  assign o_acc_busy  = (state == ACCUM);
  assign o_acc_valid = (state == DONE);
  assign o_acc_val   = acc;
  assign o_acc_ovf   = ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator at ACC_WIDTH=32; overflow expectations follow MAC_ACC_SAT_EN.
module tb_mac_accumulator;

  localparam int IN_W  = 32;
  localparam int ACC_W = 32;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [IN_W-1:0]  val_in = '0;
  logic             valid_in = 1'b0;
  logic             busy;
  logic [ACC_W-1:0] val_out;
  logic             valid_out;
  logic             ovf;

  int total = 0;
  int bad   = 0;

  mac_accumulator #(.IN_WIDTH(IN_W), .ACC_WIDTH(ACC_W), .LEN_WIDTH(LEN_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_acc_start (start),
    .i_acc_len   (len),
    .i_acc_val   (val_in),
    .i_acc_valid (valid_in),
    .o_acc_busy  (busy),
    .o_acc_val   (val_out),
    .o_acc_valid (valid_out),
    .o_acc_ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Present inputs for one rising edge, then sample outputs 1 time unit later.
  task automatic drive(input logic s, input logic [LEN_W-1:0] l, input logic v, input logic [IN_W-1:0] d);
    start    = s;
    len      = l;
    valid_in = v;
    val_in   = d;
    @(posedge clk);
    #1;
    start    = 1'b0;
    len      = '0;
    valid_in = 1'b0;
    val_in   = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; len = 8'd3; valid_in = 1'b1; val_in = 32'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    total++; if (val_out !== 32'd0) begin bad++; $display("FAIL reset_val: got %h want 0", val_out); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst = 1'b0; start = 1'b0; len = '0; valid_in = 1'b0; val_in = '0;
    drive(0, 0, 0, 0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    int busy_cnt = 0;
    logic early = 1'b0;
    drive(1, 8'd4, 0, 0);
    if (busy) busy_cnt++;
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 1, 32'(i * 10));
      if (busy) busy_cnt++;
      if (valid_out) early = 1'b1;
    end
    drive(0, 0, 1, 32'd40);
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", valid_out); end
    total++; if (val_out !== 32'd100) begin bad++; $display("FAIL basic_val: got %0d want 100", val_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    total++; if (busy_cnt != 4) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 4", busy_cnt); end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", early); end
    drive(0, 0, 0, 0);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL basic_pulse_len: got %b want 0", valid_out); end
    total++; if (val_out !== 32'd100) begin bad++; $display("FAIL basic_hold: got %0d want 100", val_out); end
  endtask

  task automatic test_gaps;
    drive(1, 8'd3, 0, 0);
    drive(0, 0, 1, 32'd5);
    drive(0, 0, 0, 32'd99);
    drive(0, 0, 0, 32'd99);
    total++; if (busy !== 1'b1 || valid_out !== 1'b0) begin
      bad++; $display("FAIL gaps_hold: got busy=%b valid=%b want busy=1 valid=0", busy, valid_out); end
    drive(0, 0, 1, 32'd7);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL gaps_early: got %b want 0", valid_out); end
    drive(0, 0, 1, 32'd9);
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL gaps_valid: got %b want 1", valid_out); end
    total++; if (val_out !== 32'd21) begin bad++; $display("FAIL gaps_val: got %0d want 21", val_out); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    drive(1, 8'd0, 1, 32'd55);
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL b2b_zero_valid: got %b want 1", valid_out); end
    total++; if (val_out !== 32'd0) begin bad++; $display("FAIL b2b_zero_val: got %0d want 0", val_out); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL b2b_zero_ovf: got %b want 0", ovf); end
    drive(1, 8'd2, 0, 0);
    total++; if (busy !== 1'b1 || valid_out !== 1'b0) begin
      bad++; $display("FAIL b2b_restart: got busy=%b valid=%b want busy=1 valid=0", busy, valid_out); end
    drive(0, 0, 1, 32'd1);
    drive(0, 0, 1, 32'd2);
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b want 1", valid_out); end
    total++; if (val_out !== 32'd3) begin bad++; $display("FAIL b2b_val: got %0d want 3", val_out); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_overflow;
`ifdef MAC_ACC_SAT_EN
    logic [ACC_W-1:0] exp2 = 32'hFFFF_FFFF;
    logic [ACC_W-1:0] exp3 = 32'hFFFF_FFFF;
`else
    logic [ACC_W-1:0] exp2 = 32'h0000_0001;
    logic [ACC_W-1:0] exp3 = 32'h0000_0006;
`endif
    drive(1, 8'd2, 0, 0);
    drive(0, 0, 1, 32'hFFFF_FFFF);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_not_yet: got %b want 0", ovf); end
    drive(0, 0, 1, 32'h2);
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %b want 1", valid_out); end
    total++; if (val_out !== exp2) begin bad++; $display("FAIL ovf_val: got %h want %h", val_out, exp2); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    drive(0, 0, 0, 0);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_hold: got %b want 1", ovf); end
    drive(1, 8'd3, 0, 0);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear_on_start: got %b want 0", ovf); end
    drive(0, 0, 1, 32'hFFFF_FFFF);
    drive(0, 0, 1, 32'h2);
    drive(0, 0, 1, 32'h5);
    total++; if (val_out !== exp3) begin bad++; $display("FAIL ovf_after_val: got %h want %h", val_out, exp3); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    logic seen = 1'b0;
    drive(1, 8'd4, 0, 0);
    drive(0, 0, 1, 32'd1);
    drive(0, 0, 1, 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (busy !== 1'b0 || valid_out !== 1'b0 || val_out !== 32'd0 || ovf !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs: got busy=%b valid=%b val=%h ovf=%b want all 0", busy, valid_out, val_out, ovf); end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0);
      if (valid_out) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_pulse: got %b want 0", seen); end
    drive(1, 8'd1, 0, 0);
    drive(0, 0, 1, 32'd7);
    total++; if (valid_out !== 1'b1 || val_out !== 32'd7) begin
      bad++; $display("FAIL midrst_rerun: got valid=%b val=%0d want valid=1 val=7", valid_out, val_out); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_ignore;
    drive(0, 0, 1, 32'd50);
    total++; if (busy !== 1'b0 || valid_out !== 1'b0 || val_out !== 32'd7) begin
      bad++; $display("FAIL ign_idle_valid: got busy=%b valid=%b val=%0d want 0 0 7", busy, valid_out, val_out); end
    drive(1, 8'd2, 1, 32'd100);
    total++; if (busy !== 1'b1 || val_out !== 32'd0) begin
      bad++; $display("FAIL ign_start_cycle_valid: got busy=%b val=%0d want busy=1 val=0", busy, val_out); end
    drive(1, 8'd5, 1, 32'd3);
    total++; if (busy !== 1'b1 || val_out !== 32'd3) begin
      bad++; $display("FAIL ign_start_in_accum: got busy=%b val=%0d want busy=1 val=3", busy, val_out); end
    drive(0, 0, 1, 32'd4);
    total++; if (valid_out !== 1'b1 || val_out !== 32'd7) begin
      bad++; $display("FAIL ign_result: got valid=%b val=%0d want valid=1 val=7", valid_out, val_out); end
    drive(0, 0, 0, 0);
    total++; if (busy !== 1'b0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL ign_back_idle: got busy=%b valid=%b want 0 0", busy, valid_out); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gaps;
    test_back_to_back;
    test_overflow;
    test_reset_mid;
    test_ignore;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, meaning product width (matches multiplier output).
REQ-002 SHALL have parameter ACC_WIDTH, default 40, meaning accumulator and result width (ACC_WIDTH >= IN_WIDTH).
REQ-003 SHALL have parameter LEN_WIDTH, default 8, meaning width of the dot-product length field.
REQ-004 SHALL have port i_clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_acc_start  input  1  single-cycle request to begin a new accumulation.
REQ-007 SHALL have port i_acc_len  input  LEN_WIDTH  number of products to sum; sampled only with an accepted start.
REQ-008 SHALL have port i_acc_val  input  IN_WIDTH  unsigned product from the multiplier.
REQ-009 SHALL have port i_acc_valid  input  1  i_acc_val is valid this cycle.
REQ-010 SHALL have port o_acc_busy  output  1  high while in ACCUM.
REQ-011 SHALL have port o_acc_val  output  ACC_WIDTH  registered accumulation result.
REQ-012 SHALL have port o_acc_valid  output  1  single-cycle pulse marking o_acc_val as a new result.
REQ-013 SHALL have port o_acc_ovf  output  1  overflow flag for the current/last result.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE; o_acc_busy = (state == ACCUM); o_acc_valid = (state == DONE).
REQ-015 SHALL accept i_acc_start only in IDLE or DONE; start in ACCUM is ignored with no effect.
REQ-016 On accepted start with i_acc_len != 0: SHALL clear the accumulator and ovf, load the remaining count = i_acc_len, and go to ACCUM.
REQ-017 On accepted start with i_acc_len == 0: SHALL go directly to DONE with o_acc_val = 0 and o_acc_ovf = 0.
REQ-018 In ACCUM, each cycle with i_acc_valid=1 SHALL add zero-extended i_acc_val to the accumulator and decrement the remaining count; cycles with i_acc_valid=0 SHALL hold the state.
REQ-019 When the valid that takes the count from 1 to 0 is sampled, SHALL enter DONE next cycle with o_acc_val = final sum; latency is 1 cycle from last product to o_acc_valid.
REQ-020 DONE SHALL last exactly one cycle, then go to IDLE, or to ACCUM/DONE if a start is accepted in that cycle (back-to-back operation, zero bubble).
REQ-021 i_acc_valid in IDLE or DONE (including in the same cycle as the start) SHALL be ignored; the first counted product is in the cycle after the start.
REQ-022 o_acc_val and o_acc_ovf SHALL hold their last values from DONE until the next accepted start.
REQ-023 Arithmetic SHALL be unsigned; without saturation the sum wraps modulo 2^ACC_WIDTH.

Reset
REQ-024 i_rst SHALL force state IDLE, accumulator 0, count 0, o_acc_val 0, o_acc_valid 0, o_acc_busy 0, o_acc_ovf 0 on the next edge, with priority over all inputs.
REQ-025 Reset during ACCUM SHALL abandon the operation with no o_acc_valid pulse.

Configuration
REQ-026 Macro MAC_ACC_SAT_EN defined: an add whose true sum exceeds 2^ACC_WIDTH-1 SHALL clamp the accumulator to 2^ACC_WIDTH-1 and set o_acc_ovf (sticky until next start); later adds keep the clamped value.
REQ-027 Macro MAC_ACC_SAT_EN undefined: SHALL wrap per REQ-023; o_acc_ovf SHALL be set on carry-out (sticky until next start) while the value still wraps.

Verification
REQ-028 start, len=4; valids with 10,20,30,40 on consecutive cycles -> o_acc_valid pulses 1 cycle after 40, o_acc_val=100, o_acc_busy high for exactly 4 cycles.
REQ-029 start, len=3; products 5,(gap 2 cycles),7,9 -> o_acc_val=21, pulse 1 cycle after 9; gaps do not count.
REQ-030 start, len=0 -> o_acc_valid next cycle, o_acc_val=0; then start len=2 in the DONE cycle, products 1,2 -> second result 3 with no idle cycle between.
REQ-031 ACC_WIDTH=32, len=2, products 0xFFFFFFFF,0x2 -> with MAC_ACC_SAT_EN: o_acc_val=0xFFFFFFFF, ovf=1; without: o_acc_val=0x1, ovf=1.
REQ-032 start, len=4, 2 products, then i_rst 1 cycle -> all outputs 0, no valid pulse; subsequent start len=1, product 7 -> o_acc_val=7.
REQ-033 start in ACCUM with different len, plus valid in IDLE -> ignored; original len=2 run with 3,4 gives 7.
